// File: rtl/rvx_debounce_cell.sv
// -----------------------------------------------------------------------------
// rvx_debounce_cell
// One GPIO channel: two-flop synchronizer, stability counter and registered
// edge strobes. A new level is accepted once the synchronized input has
// differed from the current stable level for DEBOUNCE_CYCLES consecutive
// samples; any sample that matches the stable level restarts the count.
//
// Ports
//   clock    : rising-edge clock for all state
//   reset_n  : synchronous, active-low reset
//   raw      : asynchronous pad level
//   level    : debounced (stable) level
//   rise     : one-cycle strobe when level goes 0->1
//   fall     : one-cycle strobe when level goes 1->0
// -----------------------------------------------------------------------------
module rvx_debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    // Clamped to at least one bit so an illegal DEBOUNCE_CYCLES still reaches
    // the readable elaboration error below instead of a zero-width vector.
    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
            $error("rvx_debounce_cell: DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    // NOTE: raw is asynchronous to clock; only sync2 may be used by the
    // counter logic, sync1 exists solely to let metastability settle.
    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others (sync2 <= sync1 must not shortcut).
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            count <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 == level) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                // Strobes are set on the same edge as level, so they line up
                // with the first cycle that shows the new level.
                level <= sync2;
                count <= '0;
                rise  <= sync2;
                fall  <= ~sync2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvx_gpio_debouncer.sv
// -----------------------------------------------------------------------------
// rvx_gpio_debouncer
// GPIO_WIDTH independent debounce channels plus a combined edge interrupt.
//
// Ports
//   clock            : rising-edge clock
//   reset_n          : synchronous, active-low reset
//   raw_input        : asynchronous pad levels
//   debounced_output : filtered levels (to the MCU gpio_input)
//   rise_pulse       : per-channel one-cycle strobe on accepted 0->1
//   fall_pulse       : per-channel one-cycle strobe on accepted 1->0
//   edge_irq         : OR of all rise/fall strobes, same cycle as the strobes
// -----------------------------------------------------------------------------
module rvx_gpio_debouncer #(
    parameter int GPIO_WIDTH      = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [GPIO_WIDTH-1:0] raw_input,
    output logic [GPIO_WIDTH-1:0] debounced_output,
    output logic [GPIO_WIDTH-1:0] rise_pulse,
    output logic [GPIO_WIDTH-1:0] fall_pulse,
    output logic                  edge_irq
);

    generate
        for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_cell
            rvx_debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_cell (
                .clock  (clock),
                .reset_n(reset_n),
                .raw    (raw_input[gi]),
                .level  (debounced_output[gi]),
                .rise   (rise_pulse[gi]),
                .fall   (fall_pulse[gi])
            );
        end
    endgenerate

    // Pulses are already registered, so the interrupt is a plain OR with no
    // extra latency.
    assign edge_irq = |{rise_pulse, fall_pulse};

endmodule

// File: tb/tb_rvx_gpio_debouncer.sv
// -----------------------------------------------------------------------------
// tb_rvx_gpio_debouncer
// Directed bench for two instances: u_w3 (3 channels, 4-sample filter) and
// u_d1 (default single channel, 1-sample filter). Inputs are driven 1 ns after
// a rising edge ("edge 0"); outputs are sampled 1 ns after each later edge k.
// Observation vectors: {debounced_output, rise_pulse, fall_pulse, edge_irq}.
// -----------------------------------------------------------------------------
module tb_rvx_gpio_debouncer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [2:0] raw_a;
    logic [0:0] raw_b;

    logic [2:0] dbo_a, rise_a, fall_a;
    logic       irq_a;
    logic [0:0] dbo_b, rise_b, fall_b;
    logic       irq_b;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    rvx_gpio_debouncer #(
        .GPIO_WIDTH     (3),
        .DEBOUNCE_CYCLES(4)
    ) u_w3 (
        .clock           (clock),
        .reset_n         (reset_n),
        .raw_input       (raw_a),
        .debounced_output(dbo_a),
        .rise_pulse      (rise_a),
        .fall_pulse      (fall_a),
        .edge_irq        (irq_a)
    );

    rvx_gpio_debouncer #(
        .DEBOUNCE_CYCLES(1)
    ) u_d1 (
        .clock           (clock),
        .reset_n         (reset_n),
        .raw_input       (raw_b),
        .debounced_output(dbo_b),
        .rise_pulse      (rise_b),
        .fall_pulse      (fall_b),
        .edge_irq        (irq_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset with raw levels high must still hold every output at 0.
    task automatic test_reset();
        reset_n = 1'b0;
        raw_a   = 3'b111;
        raw_b   = 1'b1;
        tick();
        tick();
        checks++;
        if ({dbo_a, rise_a, fall_a, irq_a} !== 10'b0) begin
            failures++;
            $display("FAIL reset_w3: got %b expected %b", {dbo_a, rise_a, fall_a, irq_a}, 10'b0);
        end
        checks++;
        if ({dbo_b, rise_b, fall_b, irq_b} !== 4'b0) begin
            failures++;
            $display("FAIL reset_d1: got %b expected %b", {dbo_b, rise_b, fall_b, irq_b}, 4'b0);
        end
        raw_a   = 3'b000;
        raw_b   = 1'b0;
        reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if ({dbo_a, rise_a, fall_a, irq_a, dbo_b, rise_b, fall_b, irq_b} !== 14'b0) begin
                failures++;
                $display("FAIL reset_idle edge %0d: got %b expected all zero", k,
                         {dbo_a, rise_a, fall_a, irq_a, dbo_b, rise_b, fall_b, irq_b});
            end
        end
    endtask

    // Clean 0->1 then 1->0 on channel 0: new level visible from edge 6.
    task automatic test_rise_fall();
        logic [2:0] d, r, f;
        logic [9:0] exp_v;
        raw_a = 3'b001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            d = (k >= 6) ? 3'b001 : 3'b000;
            r = (k == 6) ? 3'b001 : 3'b000;
            f = 3'b000;
            exp_v = {d, r, f, |{r, f}};
            checks++;
            if ({dbo_a, rise_a, fall_a, irq_a} !== exp_v) begin
                failures++;
                $display("FAIL rise_d4 edge %0d: got %b expected %b", k, {dbo_a, rise_a, fall_a, irq_a}, exp_v);
            end
        end
        raw_a = 3'b000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            d = (k < 6) ? 3'b001 : 3'b000;
            r = 3'b000;
            f = (k == 6) ? 3'b001 : 3'b000;
            exp_v = {d, r, f, |{r, f}};
            checks++;
            if ({dbo_a, rise_a, fall_a, irq_a} !== exp_v) begin
                failures++;
                $display("FAIL fall_d4 edge %0d: got %b expected %b", k, {dbo_a, rise_a, fall_a, irq_a}, exp_v);
            end
        end
    endtask

    // 1-sample and 3-sample glitches are rejected; a 4-sample pulse is the
    // shortest accepted one (rise at edge 6, fall at edge 10).
    task automatic test_glitch();
        logic [2:0] d, r, f;
        logic [9:0] exp_v;
        int len [2] = '{1, 3};
        for (int g = 0; g < 2; g++) begin
            raw_a = 3'b001;
            for (int k = 1; k <= 10; k++) begin
                tick();
                if (k == len[g]) raw_a = 3'b000;
                checks++;
                if ({dbo_a, rise_a, fall_a, irq_a} !== 10'b0) begin
                    failures++;
                    $display("FAIL glitch_%0d edge %0d: got %b expected %b", len[g], k,
                             {dbo_a, rise_a, fall_a, irq_a}, 10'b0);
                end
            end
        end
        raw_a = 3'b001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 4) raw_a = 3'b000;
            d = (k >= 6 && k < 10) ? 3'b001 : 3'b000;
            r = (k == 6) ? 3'b001 : 3'b000;
            f = (k == 10) ? 3'b001 : 3'b000;
            exp_v = {d, r, f, |{r, f}};
            checks++;
            if ({dbo_a, rise_a, fall_a, irq_a} !== exp_v) begin
                failures++;
                $display("FAIL pulse_4 edge %0d: got %b expected %b", k, {dbo_a, rise_a, fall_a, irq_a}, exp_v);
            end
        end
    endtask

    // Toggling every 2 cycles never survives a 4-sample filter.
    task automatic test_chatter();
        for (int c = 0; c < 48; c++) begin
            raw_a = (c < 40 && ((c / 2) % 2 == 0)) ? 3'b001 : 3'b000;
            tick();
            checks++;
            if ({dbo_a, rise_a, fall_a, irq_a} !== 10'b0) begin
                failures++;
                $display("FAIL chatter cycle %0d: got %b expected %b", c, {dbo_a, rise_a, fall_a, irq_a}, 10'b0);
            end
        end
    endtask

    // Channels 0 and 2 rise together; on the way back channel 1 glitches
    // without disturbing the others' timing.
    task automatic test_back_to_back();
        logic [2:0] d, r, f;
        logic [9:0] exp_v;
        raw_a = 3'b101;
        for (int k = 1; k <= 8; k++) begin
            tick();
            d = (k >= 6) ? 3'b101 : 3'b000;
            r = (k == 6) ? 3'b101 : 3'b000;
            f = 3'b000;
            exp_v = {d, r, f, |{r, f}};
            checks++;
            if ({dbo_a, rise_a, fall_a, irq_a} !== exp_v) begin
                failures++;
                $display("FAIL multi_rise edge %0d: got %b expected %b", k, {dbo_a, rise_a, fall_a, irq_a}, exp_v);
            end
        end
        raw_a = 3'b010;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 2) raw_a = 3'b000;
            d = (k < 6) ? 3'b101 : 3'b000;
            r = 3'b000;
            f = (k == 6) ? 3'b101 : 3'b000;
            exp_v = {d, r, f, |{r, f}};
            checks++;
            if ({dbo_a, rise_a, fall_a, irq_a} !== exp_v) begin
                failures++;
                $display("FAIL multi_fall edge %0d: got %b expected %b", k, {dbo_a, rise_a, fall_a, irq_a}, exp_v);
            end
        end
    endtask

    // Reset one sample short of acceptance discards the count; with raw still
    // high at release the rise comes exactly 6 edges later.
    task automatic test_reset_mid();
        logic [2:0] d, r, f;
        logic [9:0] exp_v;
        raw_a = 3'b001;
        for (int k = 1; k <= 8; k++) begin
            if (k == 6) reset_n = 1'b0;
            tick();
            checks++;
            if ({dbo_a, rise_a, fall_a, irq_a} !== 10'b0) begin
                failures++;
                $display("FAIL reset_mid_abort edge %0d: got %b expected %b", k,
                         {dbo_a, rise_a, fall_a, irq_a}, 10'b0);
            end
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            d = (k >= 6) ? 3'b001 : 3'b000;
            r = (k == 6) ? 3'b001 : 3'b000;
            f = 3'b000;
            exp_v = {d, r, f, |{r, f}};
            checks++;
            if ({dbo_a, rise_a, fall_a, irq_a} !== exp_v) begin
                failures++;
                $display("FAIL reset_release edge %0d: got %b expected %b", k, {dbo_a, rise_a, fall_a, irq_a}, exp_v);
            end
        end
        raw_a = 3'b000;
        for (int k = 1; k <= 8; k++) tick();
        checks++;
        if ({dbo_a, rise_a, fall_a, irq_a} !== 10'b0) begin
            failures++;
            $display("FAIL reset_mid_cleanup: got %b expected %b", {dbo_a, rise_a, fall_a, irq_a}, 10'b0);
        end
    endtask

    // One-sample filter: latency 3, and a single-cycle raw pulse passes.
    task automatic test_d1();
        logic [3:0] exp_v;
        logic       d, r, f;
        reset_n = 1'b0;
        raw_b   = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            d = (k >= 3);
            r = (k == 3);
            f = 1'b0;
            exp_v = {d, r, f, r | f};
            checks++;
            if ({dbo_b, rise_b, fall_b, irq_b} !== exp_v) begin
                failures++;
                $display("FAIL d1_rise edge %0d: got %b expected %b", k, {dbo_b, rise_b, fall_b, irq_b}, exp_v);
            end
        end
        raw_b = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            d = (k < 3);
            r = 1'b0;
            f = (k == 3);
            exp_v = {d, r, f, r | f};
            checks++;
            if ({dbo_b, rise_b, fall_b, irq_b} !== exp_v) begin
                failures++;
                $display("FAIL d1_fall edge %0d: got %b expected %b", k, {dbo_b, rise_b, fall_b, irq_b}, exp_v);
            end
        end
        raw_b = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) raw_b = 1'b0;
            d = (k == 3);
            r = (k == 3);
            f = (k == 4);
            exp_v = {d, r, f, r | f};
            checks++;
            if ({dbo_b, rise_b, fall_b, irq_b} !== exp_v) begin
                failures++;
                $display("FAIL d1_glitch edge %0d: got %b expected %b", k, {dbo_b, rise_b, fall_b, irq_b}, exp_v);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        raw_a   = 3'b000;
        raw_b   = 1'b0;
        test_reset();
        test_rise_fall();
        test_glitch();
        test_chatter();
        test_back_to_back();
        test_reset_mid();
        test_d1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
